my_boot_ctrl: RTL and testbench

MY_BOOT_CTRL -- requirements
Module: my_boot_ctrl

---
 rtl/my_boot_ctrl_if.sv | 29 ++
 rtl/my_boot_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_my_boot_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/my_boot_ctrl_if.sv
// ============================================================================
// Module      : my_boot_ctrl_if
// Description : Boot stream input and instruction-memory write bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface my_boot_ctrl_if #(
    parameter int AW = 15
);
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, rom_we, rom_addr, rom_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, rom_we, rom_addr, rom_data
    );
endinterface

`default_nettype wire

// File: rtl/my_boot_ctrl.sv
// ============================================================================
// Module      : my_boot_ctrl
// Description : Loads a length-prefixed boot image into instruction memory,
//               then releases and gates the CPU. Define BOOT_CHECKSUM_EN to
//               require a trailing 16-bit additive checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_boot_ctrl #(
    parameter int AW = 15
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        boot_start,
    input  wire logic        halt,
    my_boot_ctrl_if.slave    bus,
    output logic             cpu_reset,
    output logic             cpu_run,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_RUN   = 3'd4,
        S_PAUSE = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam int unsigned  c_MAX_LEN = 32'd1 << AW;
    localparam logic [AW:0]  c_ONE     = (AW+1)'(1);

    state_t        r_state, w_state_next;
    logic [AW:0]   r_count, w_count_next;
    logic [AW:0]   r_len,   w_len_next;
    logic          r_done,  w_done_next;
    logic          r_error, w_error_next;
    logic          r_in_ready;
    logic          r_cpu_reset;
    logic          r_cpu_run;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_data;
    logic          w_wr;
    logic          w_xfer;
    logic          w_loading;
    logic          w_len_bad;
    logic          w_last;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0]   r_csum, w_csum_next;
`endif

    assign w_xfer    = bus.in_valid & r_in_ready;
    assign w_loading = (r_state == S_LEN) || (r_state == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                       || (r_state == S_CSUM)
`endif
                       ;
    assign w_len_bad = (bus.in_data == 16'd0) || (32'(bus.in_data) > c_MAX_LEN);
    assign w_last    = (r_count == (r_len - c_ONE));

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_len_next   = r_len;
        w_done_next  = r_done;
        w_error_next = r_error;
        w_wr         = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        w_csum_next  = r_csum;
`endif
        // boot_start outranks halt and is only honoured outside a load
        if (boot_start && !w_loading) begin
            w_state_next = S_LEN;
            w_count_next = '0;
            w_done_next  = 1'b0;
            w_error_next = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            w_csum_next  = '0;
`endif
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_xfer) begin
                        if (w_len_bad) begin
                            w_state_next = S_ERROR;
                            w_error_next = 1'b1;
                        end else begin
                            w_len_next   = (AW+1)'(bus.in_data);
                            w_state_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        w_wr         = 1'b1;
                        w_count_next = r_count + c_ONE;
`ifdef BOOT_CHECKSUM_EN
                        w_csum_next  = r_csum + bus.in_data;
                        if (w_last) w_state_next = S_CSUM;
`else
                        if (w_last) begin
                            w_state_next = S_RUN;
                            w_done_next  = 1'b1;
                        end
`endif
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        if (bus.in_data == r_csum) begin
                            w_state_next = S_RUN;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = S_ERROR;
                            w_error_next = 1'b1;
                        end
                    end
                end
`endif
                S_RUN:   if (halt)  w_state_next = S_PAUSE;
                S_PAUSE: if (!halt) w_state_next = S_RUN;
                S_IDLE, S_ERROR: ;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Handshake and CPU controls are decoded from the next state so they are
    // true flops aligned with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_len       <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_cpu_run   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_len       <= w_len_next;
            r_done      <= w_done_next;
            r_error     <= w_error_next;
            r_in_ready  <= (w_state_next == S_LEN) || (w_state_next == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                           || (w_state_next == S_CSUM)
`endif
                           ;
            r_cpu_reset <= !((w_state_next == S_RUN) || (w_state_next == S_PAUSE));
            r_cpu_run   <= (w_state_next == S_RUN);
            r_we        <= w_wr;
            if (w_wr) begin
                r_addr  <= r_count[AW-1:0];
                r_data  <= bus.in_data;
            end
`ifdef BOOT_CHECKSUM_EN
            r_csum      <= w_csum_next;
`endif
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.rom_we   = r_we;
    assign bus.rom_addr = r_addr;
    assign bus.rom_data = r_data;
    assign cpu_reset    = r_cpu_reset;
    assign cpu_run      = r_cpu_run;
    assign done         = r_done;
    assign error        = r_error;

endmodule

`default_nettype wire

// File: tb/tb_my_boot_ctrl.sv
// ============================================================================
// Module      : tb_my_boot_ctrl
// Description : Scoreboard bench for my_boot_ctrl (small AW for boundary loads)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_my_boot_ctrl;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic boot_start = 1'b0;
    logic halt = 1'b0;
    logic cpu_reset, cpu_run, done, error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [15:0] m_sum;

    my_boot_ctrl_if #(.AW(AW)) bus ();

    my_boot_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .boot_start (boot_start),
        .halt       (halt),
        .bus        (bus.slave),
        .cpu_reset  (cpu_reset),
        .cpu_run    (cpu_run),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every rom_we pulse must match the oldest expected write
    always @(negedge clk) begin
        if (bus.rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.rom_addr), 32'(e[31:16]));
                check("wr_data", 32'(bus.rom_data), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boot();
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        m_sum = 16'd0;
    endtask

    task automatic send(input logic [15:0] w, input bit is_data, input int addr, input int gap);
        int cnt;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        if (is_data) begin
            exp_q.push_back({16'(addr), w});
            m_sum = m_sum + w;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        if (cnt >= 50) check("ready_timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_csum(input int gap);
`ifdef BOOT_CHECKSUM_EN
        send(m_sum, 1'b0, 0, gap);
`else
        repeat (gap) tick();
`endif
    endtask

    task automatic expect_run(input string tag);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        tick();
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_rom_we"}, 32'(bus.rom_we), 32'd0);
        check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check({tag, "_rom_data"}, 32'(bus.rom_data), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] words [3];
        words[0] = 16'h0010;
        words[1] = 16'hEC10;
        words[2] = 16'hE308;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'd0;
        m_sum = 16'd0;

        repeat (3) tick();
        expect_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Reference stream, back to back
        boot();
        check("boot_in_ready", 32'(bus.in_ready), 32'd1);
        check("boot_cpu_reset", 32'(cpu_reset), 32'd1);
        send(16'd3, 1'b0, 0, 0);
        for (int k = 0; k < 3; k++) send(words[k], 1'b1, k, 0);
        send_csum(0);
        expect_run("ref");

        // Halt for five cycles
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_cpu_run", 32'(cpu_run), 32'd0);
            check("halt_cpu_reset", 32'(cpu_reset), 32'd0);
        end
        halt = 1'b0;
        tick();
        check("unhalt_cpu_run", 32'(cpu_run), 32'd1);

        // boot_start beats halt; then zero length
        halt = 1'b1;
        boot();
        halt = 1'b0;
        check("prio_in_ready", 32'(bus.in_ready), 32'd1);
        check("prio_cpu_reset", 32'(cpu_reset), 32'd1);
        check("prio_done", 32'(done), 32'd0);
        send(16'd0, 1'b0, 0, 0);
        check("len0_error", 32'(error), 32'd1);
        check("len0_cpu_reset", 32'(cpu_reset), 32'd1);
        check("len0_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (4) tick();
        check("err_sticky", 32'(error), 32'd1);
        boot();
        check("err_cleared", 32'(error), 32'd0);

        // Length one beyond the address space
        send(16'((1 << AW) + 1), 1'b0, 0, 1);
        check("len_big_error", 32'(error), 32'd1);
        boot();

        // Largest legal length fills every address
        send(16'(1 << AW), 1'b0, 0, 0);
        for (int k = 0; k < (1 << AW); k++)
            send(16'($urandom), 1'b1, k, $urandom_range(0, 2));
        send_csum(1);
        expect_run("full");

        // Reference stream again with random in_valid gaps
        boot();
        send(16'd3, 1'b0, 0, $urandom_range(0, 3));
        for (int k = 0; k < 3; k++) send(words[k], 1'b1, k, $urandom_range(1, 4));
        send_csum($urandom_range(0, 3));
        expect_run("gaps");

        // Reset in the middle of DATA; boot_start there is ignored
        boot();
        send(16'd4, 1'b0, 0, 0);
        send(16'hA5A5, 1'b1, 0, 0);
        send(16'h5A5A, 1'b1, 1, 2);
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        check("bs_ignored_in_ready", 32'(bus.in_ready), 32'd1);
        #2 reset = 1'b1;
        #1 expect_reset_outputs("mid");
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("mid_idle_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum
        boot();
        send(16'd2, 1'b0, 0, 0);
        send(16'h0001, 1'b1, 0, 0);
        send(16'h0002, 1'b1, 1, 0);
        send(16'h0004, 1'b0, 0, 0);
        check("csum_error", 32'(error), 32'd1);
        check("csum_cpu_reset", 32'(cpu_reset), 32'd1);
        check("csum_done", 32'(done), 32'd0);
        tick();
        check("csum_q_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
